// File: rtl/tile_engine.sv
// Falling-tile game engine: ROWS x COLS matrix, key judging, score/miss/frame counters, IDLE/PLAY/OVER FSM.
// Latency: state/counters update 1 clk after the input cycle; row_ready is combinational (playing & tick).
// Backpressure: a row is taken only on a PLAY tick, never buffered. Optional COMBO_MULT_EN enables the combo multiplier.
module tile_engine #(
    parameter int COLS       = 16,
    parameter int ROWS       = 12,
    parameter int SCORE_W    = 12,
    parameter int HIT_PTS    = 10,
    parameter int MAX_MISSES = 3,
    parameter int FRAME_W    = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   tick,
    input  logic                   start,
    input  logic [COLS-1:0]        keys,
    input  logic [COLS-1:0]        row_data,
    input  logic                   row_valid,
    output logic                   row_ready,
    output logic [ROWS*COLS-1:0]   state,
    output logic [SCORE_W-1:0]     score,
    output logic [2:0]             misses,
    output logic [7:0]             combo,
    output logic [FRAME_W-1:0]     frame,
    output logic                   playing,
    output logic                   game_over,
    output logic                   hit_pulse,
    output logic                   miss_pulse
);
    localparam int BOT = (ROWS-1)*COLS;
    localparam logic [32:0] SCORE_MAX = (33'd1 << SCORE_W) - 33'd1;

    typedef enum logic [1:0] {S_IDLE, S_PLAY, S_OVER} st_t;

    st_t                  r_st, w_st_nxt;
    logic [COLS-1:0]      r_key_q;
    logic [ROWS*COLS-1:0] r_mat, w_mat_nxt;
    logic [SCORE_W-1:0]   r_score, w_score_nxt;
    logic [2:0]           r_miss, w_miss_nxt;
    logic [FRAME_W-1:0]   r_frame, w_frame_nxt;
    logic                 r_hit_p, r_miss_p, w_hit_p_nxt, w_miss_p_nxt;

    logic [COLS-1:0]      w_edge, w_bot, w_hits, w_wrong, w_bot_post, w_top;
    logic [7:0]           w_hit_cnt;
    logic [2:0]           w_mult;
    logic [31:0]          w_add;
    logic [32:0]          w_sum;
    logic [1:0]           w_inc;
    logic [3:0]           w_miss_sum;
    logic                 w_play, w_clear;

    assign w_play     = (r_st == S_PLAY);
    assign w_clear    = start & ~w_play;
    assign w_edge     = keys & ~r_key_q;
    assign w_bot      = r_mat[BOT +: COLS];
    assign w_hits     = w_edge & w_bot;
    assign w_wrong    = w_edge & ~w_bot;
    assign w_bot_post = w_bot & ~w_hits;
    assign w_top      = row_valid ? row_data : '0;

    always_comb begin
        w_hit_cnt = 8'd0;
        for (int c = 0; c < COLS; c++) w_hit_cnt = w_hit_cnt + {7'd0, w_hits[c]};
    end

    // Wrong press and an unhit shift-out are independent miss sources in the same cycle.
    assign w_inc      = {1'b0, |w_wrong} + {1'b0, tick & |w_bot_post};
    assign w_miss_sum = {1'b0, r_miss} + {2'b00, w_inc};
    assign w_add      = 32'(HIT_PTS) * {29'd0, w_mult} * {24'd0, w_hit_cnt};
    assign w_sum      = 33'(r_score) + {1'b0, w_add};

    always_comb begin
        w_st_nxt     = r_st;
        w_mat_nxt    = r_mat;
        w_score_nxt  = r_score;
        w_miss_nxt   = r_miss;
        w_frame_nxt  = r_frame;
        w_hit_p_nxt  = 1'b0;
        w_miss_p_nxt = 1'b0;
        case (r_st)
            S_PLAY: begin
                w_mat_nxt[BOT +: COLS] = w_bot_post;
                if (tick) begin
                    w_mat_nxt   = {r_mat[BOT-1:0], w_top};
                    w_frame_nxt = r_frame + 1'b1;
                end
                w_score_nxt  = (w_sum > SCORE_MAX) ? SCORE_MAX[SCORE_W-1:0] : w_sum[SCORE_W-1:0];
                w_miss_nxt   = w_miss_sum[3] ? 3'd7 : w_miss_sum[2:0];
                w_hit_p_nxt  = |w_hits;
                w_miss_p_nxt = (w_inc != 2'd0);
                if (w_miss_nxt >= 3'(MAX_MISSES)) w_st_nxt = S_OVER;
            end
            default: begin
                if (start) begin
                    w_st_nxt    = S_PLAY;
                    w_mat_nxt   = '0;
                    w_score_nxt = '0;
                    w_miss_nxt  = '0;
                    w_frame_nxt = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_st     <= S_IDLE;
            r_key_q  <= '0;
            r_mat    <= '0;
            r_score  <= '0;
            r_miss   <= '0;
            r_frame  <= '0;
            r_hit_p  <= 1'b0;
            r_miss_p <= 1'b0;
        end else begin
            r_st     <= w_st_nxt;
            r_key_q  <= keys;
            r_mat    <= w_mat_nxt;
            r_score  <= w_score_nxt;
            r_miss   <= w_miss_nxt;
            r_frame  <= w_frame_nxt;
            r_hit_p  <= w_hit_p_nxt;
            r_miss_p <= w_miss_p_nxt;
        end
    end

`ifdef COMBO_MULT_EN
    logic [7:0] r_combo, w_combo_nxt;
    logic [8:0] w_combo_sum;

    // Multiplier uses the streak from before this cycle: 1 + combo/8, capped at 4.
    assign w_mult      = (r_combo[7:3] >= 5'd3) ? 3'd4 : 3'd1 + {1'b0, r_combo[4:3]};
    assign w_combo_sum = {1'b0, r_combo} + {1'b0, w_hit_cnt};

    always_comb begin
        w_combo_nxt = r_combo;
        if (w_clear) begin
            w_combo_nxt = 8'd0;
        end else if (w_play) begin
            if (w_inc != 2'd0)  w_combo_nxt = 8'd0;
            else if (|w_hits)   w_combo_nxt = w_combo_sum[8] ? 8'd255 : w_combo_sum[7:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_combo <= 8'd0;
        else        r_combo <= w_combo_nxt;
    end

    assign combo = r_combo;
`else
    assign w_mult = 3'd1;
    assign combo  = 8'd0;
`endif

    assign row_ready  = w_play & tick;
    assign state      = r_mat;
    assign score      = r_score;
    assign misses     = r_miss;
    assign frame      = r_frame;
    assign playing    = w_play;
    assign game_over  = (r_st == S_OVER);
    assign hit_pulse  = r_hit_p;
    assign miss_pulse = r_miss_p;
endmodule

// File: tb/tb_tile_engine.sv
// Directed bench for tile_engine (4x4): a 12-bit-score instance plus a 5-bit-score twin on the same stimulus.
module tb_tile_engine;
    logic        clk = 1'b0;
    logic        rst_n, tick, start, row_valid;
    logic [3:0]  keys, row_data;

    logic        a_row_ready, a_playing, a_game_over, a_hit_pulse, a_miss_pulse;
    logic [15:0] a_state, a_frame;
    logic [11:0] a_score;
    logic [2:0]  a_misses;
    logic [7:0]  a_combo;

    logic        b_row_ready, b_playing, b_game_over, b_hit_pulse, b_miss_pulse;
    logic [15:0] b_state, b_frame;
    logic [4:0]  b_score;
    logic [2:0]  b_misses;
    logic [7:0]  b_combo;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    tile_engine #(.COLS(4), .ROWS(4), .SCORE_W(12), .HIT_PTS(10), .MAX_MISSES(3), .FRAME_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .tick(tick), .start(start), .keys(keys),
        .row_data(row_data), .row_valid(row_valid), .row_ready(a_row_ready),
        .state(a_state), .score(a_score), .misses(a_misses), .combo(a_combo),
        .frame(a_frame), .playing(a_playing), .game_over(a_game_over),
        .hit_pulse(a_hit_pulse), .miss_pulse(a_miss_pulse));

    tile_engine #(.COLS(4), .ROWS(4), .SCORE_W(5), .HIT_PTS(10), .MAX_MISSES(3), .FRAME_W(16)) u_dut_sat (
        .clk(clk), .rst_n(rst_n), .tick(tick), .start(start), .keys(keys),
        .row_data(row_data), .row_valid(row_valid), .row_ready(b_row_ready),
        .state(b_state), .score(b_score), .misses(b_misses), .combo(b_combo),
        .frame(b_frame), .playing(b_playing), .game_over(b_game_over),
        .hit_pulse(b_hit_pulse), .miss_pulse(b_miss_pulse));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input logic [3:0] data, input logic vld);
        tick = 1'b1; row_data = data; row_valid = vld;
        cyc();
        tick = 1'b0; row_valid = 1'b0; row_data = 4'd0;
    endtask

    task automatic press(input logic [3:0] k);
        keys = k;
        cyc();
    endtask

`ifdef COMBO_MULT_EN
    localparam int EXP_COMBO8 = 8;
    localparam int EXP_COMBO9 = 9;
    localparam int EXP_SCORE9 = 100;
`else
    localparam int EXP_COMBO8 = 0;
    localparam int EXP_COMBO9 = 0;
    localparam int EXP_SCORE9 = 90;
`endif

    initial begin
        rst_n = 1'b0; tick = 1'b0; start = 1'b0; keys = 4'd0; row_data = 4'd0; row_valid = 1'b0;
        #3;
        chk("rst_state", a_state, 0);
        chk("rst_score", a_score, 0);
        chk("rst_playing", a_playing, 0);
        chk("rst_over", a_game_over, 0);
        chk("rst_frame", a_frame, 0);
        chk("rst_pulses", {a_hit_pulse, a_miss_pulse}, 0);
        repeat (2) cyc();
        rst_n = 1'b1;
        cyc();

        // Four ticks of 0001 with the row offered continuously; only ticks consume it.
        start = 1'b1; cyc(); start = 1'b0;
        chk("start_playing", a_playing, 1);
        row_data = 4'b0001; row_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("rdy_no_tick", a_row_ready, 0);
            tick = 1'b1; #1;
            chk("rdy_tick", a_row_ready, 1);
            cyc();
            tick = 1'b0;
        end
        row_valid = 1'b0;
        chk("fill_state", a_state, 16'h1111);
        chk("fill_frame", a_frame, 4);
        chk("fill_misses", a_misses, 0);

        press(4'b0001);
        chk("hit1_score", a_score, 10);
        chk("hit1_state", a_state, 16'h0111);
        chk("hit1_pulse", a_hit_pulse, 1);
        cyc();
        chk("held_no_rescore", a_score, 10);
        chk("hit_pulse_fall", a_hit_pulse, 0);
        press(4'b0000);
        feed(4'd0, 1'b0);
        chk("shift_state", a_state, 16'h1110);
        chk("shift_no_miss", a_misses, 0);
        press(4'b0001); press(4'b0000);
        feed(4'd0, 1'b0);
        press(4'b0001); press(4'b0000);
        chk("score30", a_score, 30);
        chk("score30_state", a_state, 16'h0100);

        // Asynchronous reset mid-game.
        rst_n = 1'b0; #1;
        chk("arst_score", a_score, 0);
        chk("arst_playing", a_playing, 0);
        chk("arst_state", a_state, 0);
        chk("arst_frame", a_frame, 0);
        cyc(); rst_n = 1'b1; cyc();
        tick = 1'b1; #1;
        chk("idle_rdy", a_row_ready, 0);
        cyc(); tick = 1'b0;
        chk("idle_tick_frame", a_frame, 0);

        // start and tick together in IDLE: start wins, no shift.
        start = 1'b1; tick = 1'b1; row_valid = 1'b1; row_data = 4'b0101;
        cyc();
        start = 1'b0; tick = 1'b0; row_valid = 1'b0;
        chk("st_tick_playing", a_playing, 1);
        chk("st_tick_frame", a_frame, 0);
        chk("st_tick_state", a_state, 0);
        feed(4'b0101, 1'b1); feed(4'd0, 1'b0); feed(4'd0, 1'b0); feed(4'd0, 1'b0);
        chk("b0101_state", a_state, 16'h5000);
        press(4'b0101);
        chk("dbl_score", a_score, 20);
        chk("dbl_state", a_state, 0);
        chk("dbl_pulse", a_hit_pulse, 1);
        chk("dbl_misses", a_misses, 0);
        chk("sat_twin_20", b_score, 20);
        press(4'b0000);
        start = 1'b1; cyc(); start = 1'b0;
        chk("start_in_play", a_score, 20);
        chk("start_in_play_frame", a_frame, 4);

        // Misses: unhit shift-out, wrong press, then game over.
        feed(4'b0010, 1'b1); feed(4'd0, 1'b0); feed(4'd0, 1'b0); feed(4'd0, 1'b0);
        chk("b0010_state", a_state, 16'h2000);
        feed(4'd0, 1'b0);
        chk("shiftout_miss", a_misses, 1);
        chk("shiftout_pulse", a_miss_pulse, 1);
        chk("shiftout_frame", a_frame, 9);
        cyc();
        chk("miss_pulse_fall", a_miss_pulse, 0);
        press(4'b1000);
        chk("wrong_miss", a_misses, 2);
        press(4'b0000);
        press(4'b0100);
        chk("third_miss", a_misses, 3);
        chk("over_flag", a_game_over, 1);
        chk("over_playing", a_playing, 0);
        press(4'b0000);
        feed(4'b0001, 1'b1);
        chk("over_frame", a_frame, 9);
        chk("over_state", a_state, 0);
        press(4'b0001);
        chk("over_keys_score", a_score, 20);
        chk("over_keys_misses", a_misses, 3);
        press(4'b0000);

        // Restart from OVER, then eight single-bit hits.
        start = 1'b1; cyc(); start = 1'b0;
        chk("restart_score", a_score, 0);
        chk("restart_misses", a_misses, 0);
        chk("restart_frame", a_frame, 0);
        chk("restart_over", a_game_over, 0);
        feed(4'hF, 1'b1); feed(4'hF, 1'b1); feed(4'd0, 1'b0); feed(4'd0, 1'b0);
        chk("ff_state", a_state, 16'hFF00);
        press(4'b0001); press(4'b0011); press(4'b0111); press(4'b1111);
        chk("hits4_score", a_score, 40);
        chk("hits4_state", a_state, 16'h0F00);
        press(4'b0000);
        feed(4'd0, 1'b0);
        chk("row2_down", a_state, 16'hF000);
        press(4'b0001); press(4'b0011); press(4'b0111); press(4'b1111);
        chk("hits8_score", a_score, 80);
        chk("hits8_combo", a_combo, EXP_COMBO8);
        chk("sat_twin_31", b_score, 31);
        press(4'b0000);

        // Hit in the tick cycle is judged on the pre-shift bottom row.
        feed(4'b0001, 1'b1); feed(4'd0, 1'b0); feed(4'd0, 1'b0); feed(4'd0, 1'b0);
        chk("b0001_state", a_state, 16'h1000);
        keys = 4'b0001;
        feed(4'd0, 1'b0);
        chk("tick_hit_score", a_score, EXP_SCORE9);
        chk("tick_hit_state", a_state, 0);
        chk("tick_hit_misses", a_misses, 0);
        chk("tick_hit_frame", a_frame, 10);
        chk("tick_hit_combo", a_combo, EXP_COMBO9);
        chk("sat_twin_hold", b_score, 31);
        press(4'b0000);
        press(4'b0010);
        chk("combo_miss", a_misses, 1);
        chk("combo_reset", a_combo, 0);
        press(4'b0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
